// File: rtl/tis_pkg.sv
// Shared types, range limits and the saturating clamp used by the core,
// the stream source and the stream sink.
package tis_pkg;

  typedef logic signed [10:0] word_t;

  localparam word_t TIS_MAX = 11'sd999;
  localparam word_t TIS_MIN = -11'sd999;

  typedef enum logic [1:0] {
    IDLE,
    OFFER,
    GAP,
    DONE
  } src_state_t;

  // Saturate a raw 11-bit word into the accumulator range of the core.
  function automatic word_t tis_clamp(input word_t w);
    if (w > TIS_MAX) begin
      return TIS_MAX;
    end
    if (w < TIS_MIN) begin
      return TIS_MIN;
    end
    return w;
  endfunction

endpackage

// File: rtl/stream_source.sv
// Test-data writer: offers a preloaded list of clamped words on the core
// write handshake (write = offer, wready = accept) and reports how many
// words were delivered plus a sticky done flag.
module stream_source
  import tis_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GAP   = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         len,
  input  logic signed [10:0] values [0:DEPTH-1],
  input  logic               wready,
  output logic               write,
  output logic signed [10:0] out,
  output logic [7:0]         count,
  output logic               done
);

  localparam int         IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [7:0] DEPTH_W  = 8'(DEPTH);
  localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

  src_state_t       state;
  logic [IDX_W-1:0] idx;
  logic [7:0]       total;
  logic [3:0]       gap_cnt;

  logic [7:0]       len_eff;
  logic [IDX_W-1:0] idx_next;
  word_t            word_first;
  word_t            word_cur;
  word_t            word_next;

  // Effective length and the clamped candidate words, read live from the list.
  always_comb begin
    len_eff    = (len > DEPTH_W) ? DEPTH_W : len;
    idx_next   = idx + IDX_W'(1);
    word_first = tis_clamp(values[0]);
    word_cur   = tis_clamp(values[idx]);
    word_next  = tis_clamp(values[idx_next]);
  end

  // Streaming FSM. A start arriving mid-stream first drops write for one
  // cycle (parked in GAP with an expired gap counter) so the reader sees a
  // clean boundary, then the new stream begins at entry 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      write   <= 1'b0;
      out     <= '0;
      count   <= 8'd0;
      done    <= 1'b0;
      idx     <= '0;
      total   <= 8'd0;
      gap_cnt <= 4'd0;
    end else if (start) begin
      total   <= len_eff;
      count   <= 8'd0;
      done    <= 1'b0;
      idx     <= '0;
      gap_cnt <= 4'd0;
      if (len_eff == 8'd0) begin
        state <= DONE;
        write <= 1'b0;
        done  <= 1'b1;
      end else if (state == OFFER || state == tis_pkg::GAP) begin
        state <= tis_pkg::GAP;
        write <= 1'b0;
      end else begin
        state <= OFFER;
        write <= 1'b1;
        out   <= word_first;
      end
    end else begin
      case (state)
        IDLE: begin
          write <= 1'b0;
        end
        OFFER: begin
          if (write && wready) begin
            count <= (count == 8'hFF) ? count : count + 8'd1;
            idx   <= idx_next;
            if (count + 8'd1 == total) begin
              state <= DONE;
              write <= 1'b0;
              done  <= 1'b1;
            end else if (GAP > 0) begin
              state   <= tis_pkg::GAP;
              write   <= 1'b0;
              gap_cnt <= GAP_LOAD;
            end else begin
              out <= word_next;
            end
          end
        end
        tis_pkg::GAP: begin
          if (gap_cnt == 4'd0) begin
            state <= OFFER;
            write <= 1'b1;
            out   <= word_cur;
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        DONE: begin
          write <= 1'b0;
          done  <= 1'b1;
        end
        default: begin
          state <= IDLE;
          write <= 1'b0;
        end
      endcase
    end
  end

endmodule
